// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - integer register file with WB write port, bypassed read ports and req/ack debug port
module reg_file_wb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteW,
    input  logic [AW-1:0]   RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic [AW-1:0]   Rs1D,
    input  logic [AW-1:0]   Rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            dbg_ack,
    output logic [XLEN-1:0] dbg_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dbg_state_t;

    dbg_state_t      state_q, state_d;
    logic [XLEN-1:0] regs [NREGS];
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] wdata_q;

    logic wb_wr, dbg_fire, dbg_wr;

    assign wb_wr    = RegWriteW && (RdW != '0);
    // Debug only touches the array on cycles where WB is idle.
    assign dbg_fire = (state_q == ACCESS) && !RegWriteW;
    assign dbg_wr   = dbg_fire && we_q && (addr_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_wr) begin
            regs[RdW] <= ResultW;
        end else if (dbg_wr) begin
            regs[addr_q] <= wdata_q;
        end
    end

    always_comb begin
        RD1D = '0;
        if (Rs1D != '0) begin
            if (RegWriteW && (RdW == Rs1D)) begin
                RD1D = ResultW;
            end else begin
                RD1D = regs[Rs1D];
            end
        end
    end

    always_comb begin
        RD2D = '0;
        if (Rs2D != '0) begin
            if (RegWriteW && (RdW == Rs2D)) begin
                RD2D = ResultW;
            end else begin
                RD2D = regs[Rs2D];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dbg_rdata <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && dbg_req) begin
                we_q    <= dbg_we;
                addr_q  <= dbg_addr;
                wdata_q <= dbg_wdata;
            end
            if (dbg_fire && !we_q) begin
                dbg_rdata <= (addr_q == '0) ? '0 : regs[addr_q];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dbg_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (dbg_req) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!RegWriteW) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                dbg_ack = 1'b1;
                if (!dbg_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - self-checking bench for reg_file_wb against an array reference model
module tb_reg_file_wb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            RegWriteW;
    logic [AW-1:0]   RdW;
    logic [XLEN-1:0] ResultW;
    logic [AW-1:0]   Rs1D, Rs2D;
    logic [XLEN-1:0] RD1D, RD2D;
    logic            dbg_req, dbg_we;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_wdata;
    logic            dbg_ack;
    logic [XLEN-1:0] dbg_rdata;

    logic [XLEN-1:0] model [NREGS];
    int n_checks = 0;
    int n_fail   = 0;

    reg_file_wb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] idx);
        if (idx == '0) return '0;
        if (RegWriteW && (RdW == idx)) return ResultW;
        return model[idx];
    endfunction

    // Advance one clock; the model commits the WB write seen at the edge.
    task automatic step();
        @(posedge clk);
        if (rst_n && RegWriteW && (RdW != '0)) model[RdW] = ResultW;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        Rs1D = '0; Rs2D = '0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            Rs1D = AW'(i); Rs2D = AW'(NREGS - 1 - i);
            #1;
            n_checks++;
            if (RD1D !== '0 || RD2D !== '0) begin
                n_fail++;
                $display("FAIL reset_read idx=%0d rd1=%h rd2=%h expected 0", i, RD1D, RD2D);
            end
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (dbg_ack !== 1'b0 || dbg_rdata !== '0) begin
                n_fail++;
                $display("FAIL reset_dbg ack=%b rdata=%h expected 0/0", dbg_ack, dbg_rdata);
            end
        end
    endtask

    task automatic test_bypass();
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF; Rs1D = 5'd5; Rs2D = 5'd5;
        #1;
        n_checks++;
        if (RD1D !== 32'hDEADBEEF || RD2D !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL bypass_same_cycle rd1=%h rd2=%h expected deadbeef", RD1D, RD2D);
        end
        step();
        RegWriteW = 1'b0;
        #1;
        n_checks++;
        if (RD1D !== 32'hDEADBEEF || RD2D !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL bypass_after_edge rd1=%h rd2=%h expected deadbeef", RD1D, RD2D);
        end
    endtask

    task automatic test_x0();
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h1234; Rs1D = 5'd0; Rs2D = 5'd0;
        #1;
        n_checks++;
        if (RD1D !== '0 || RD2D !== '0) begin
            n_fail++;
            $display("FAIL x0_same_cycle rd1=%h rd2=%h expected 0", RD1D, RD2D);
        end
        step();
        RegWriteW = 1'b0;
        #1;
        n_checks++;
        if (RD1D !== '0) begin
            n_fail++;
            $display("FAIL x0_after_edge rd1=%h expected 0", RD1D);
        end
    endtask

    task automatic test_random_rw(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            RegWriteW = 1'($urandom);
            RdW = AW'($urandom);
            ResultW = $urandom;
            Rs1D = AW'($urandom);
            Rs2D = ($urandom_range(0, 3) == 0) ? RdW : AW'($urandom);
            #1;
            n_checks++;
            if (RD1D !== exp_read(Rs1D) || RD2D !== exp_read(Rs2D)) begin
                n_fail++;
                $display("FAIL random_read rs1=%0d rd1=%h exp1=%h rs2=%0d rd2=%h exp2=%h",
                         Rs1D, RD1D, exp_read(Rs1D), Rs2D, RD2D, exp_read(Rs2D));
            end
            step();
        end
        RegWriteW = 1'b0;
    endtask

    // One full four-phase debug access; stall WB writes are issued while the FSM sits in ACCESS.
    task automatic dbg_access(input logic we, input logic [AW-1:0] addr, input logic [XLEN-1:0] wdata,
                              input int stalls, input logic [AW-1:0] st_rd, input logic [XLEN-1:0] st_last);
        int e;
        logic [XLEN-1:0] exp_rd, held;
        e = 0;
        RegWriteW = 1'b0;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        while (!dbg_ack && e < 40) begin
            step();
            e++;
            if (!dbg_ack) begin
                if (e == 1) begin
                    dbg_we = 1'($urandom); dbg_addr = AW'($urandom); dbg_wdata = $urandom;
                end
                if (e <= stalls) begin
                    RegWriteW = 1'b1; RdW = st_rd;
                    ResultW = (e == stalls) ? st_last : $urandom;
                end else begin
                    RegWriteW = 1'b0;
                end
            end
        end
        RegWriteW = 1'b0;
        n_checks++;
        if (dbg_ack !== 1'b1 || e != 2 + stalls) begin
            n_fail++;
            $display("FAIL dbg_latency addr=%0d we=%b edges=%0d expected %0d ack=%b", addr, we, e, 2 + stalls, dbg_ack);
        end
        if (we) begin
            if (addr != '0) model[addr] = wdata;
        end else begin
            exp_rd = model[addr];
            n_checks++;
            if (dbg_rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL dbg_rdata addr=%0d got %h expected %h", addr, dbg_rdata, exp_rd);
            end
        end
        held = dbg_rdata;
        dbg_req = 1'b0;
        step();
        Rs2D = addr;
        #1;
        n_checks++;
        if (dbg_ack !== 1'b0 || dbg_rdata !== held) begin
            n_fail++;
            $display("FAIL dbg_release ack=%b rdata=%h expected 0/%h", dbg_ack, dbg_rdata, held);
        end
        n_checks++;
        if (RD2D !== exp_read(addr)) begin
            n_fail++;
            $display("FAIL dbg_visibility addr=%0d rd2=%h expected %h", addr, RD2D, exp_read(addr));
        end
    endtask

    task automatic test_debug_write_read();
        dbg_access(1'b1, 5'd7, 32'hA5A5A5A5, 0, 5'd0, '0);
        dbg_access(1'b0, 5'd7, '0, 0, 5'd0, '0);
        dbg_access(1'b1, 5'd0, 32'hFFFF0000, 0, 5'd0, '0);
        dbg_access(1'b0, 5'd0, '0, 0, 5'd0, '0);
    endtask

    task automatic test_wb_priority();
        dbg_access(1'b0, 5'd9, '0, 3, 5'd9, 32'h55);
        n_checks++;
        if (dbg_rdata !== 32'h55) begin
            n_fail++;
            $display("FAIL wb_priority_rdata got %h expected 00000055", dbg_rdata);
        end
        dbg_access(1'b1, 5'd9, 32'h77, 2, 5'd9, 32'h66);
        dbg_access(1'b0, 5'd9, '0, 0, 5'd0, '0);
    endtask

    task automatic test_back_to_back(input int n);
        for (int k = 0; k < n; k++) begin
            dbg_access(1'($urandom), AW'($urandom), $urandom, $urandom_range(0, 3), AW'($urandom), $urandom);
        end
    endtask

    task automatic test_reset_mid_access();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'hFF;
        step();
        rst_n = 1'b0;
        Rs1D = 5'd3;
        #1;
        n_checks++;
        if (dbg_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ack ack=%b expected 0", dbg_ack);
        end
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        step();
        dbg_req = 1'b0;
        rst_n = 1'b1;
        step();
        #1;
        n_checks++;
        if (RD1D !== '0 || dbg_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_x3 rd1=%h ack=%b expected 0/0", RD1D, dbg_ack);
        end
        dbg_access(1'b0, 5'd3, '0, 0, 5'd0, '0);
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_x0();
        test_random_rw(200);
        test_debug_write_read();
        test_wb_priority();
        test_back_to_back(30);
        test_random_rw(100);
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
